mdc_despachador: RTL
====================

Name: mdc_despachador

Overview:
- Actuator-side responder for the coffee-machine controller (maquina_de_cafe); sits between the controller's 3-bit service command and the physical pumps and coin hopper.
- Accepts one command at a time over a valid/ready handshake.
- Sequences the coffee or tea pump for a fixed pour time, then issues coin-return pulses with a fixed gap.
- Signals completion with a one-cycle done strobe.

Parameters:
- CMD_W, 3, command width (matches controller out bus).
- POUR_CYC, 8, cycles a pump stays on per serve (>=1).
- COIN_PULSE, 2, cycles each coin-hopper pulse is high (>=1).
- COIN_GAP, 2, low cycles after each coin pulse before the next step (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd  in  CMD_W  service command from controller.
- cmd_valid  in  1  cmd is valid this cycle.
- cmd_ready  out  1  block can accept a command.
- pump_cafe  out  1  coffee pump enable.
- pump_te  out  1  tea pump enable.
- coin5_out  out  1  hopper pulse: return one 5 coin.
- coin10_out  out  1  hopper pulse: return one 10 coin.
- busy  out  1  command in progress (not IDLE).
- done  out  1  one-cycle completion strobe.
- err  out  1  one-cycle strobe, coincident with done, for a reserved command.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, counters=0.
  - All actuator outputs, done and err =0; cmd_ready=1 once reset is released.
  - Reset mid-pour or mid-pulse drops pumps and coins in the same instant; no resume.
- Command codes (shared package):
  - 000 NOP.
  - 001 SERVE_CAFE.
  - 010 SERVE_TE.
  - 011 reserved.
  - 100 RETURN_10: refund the whole coin.
  - 101 SERVE_TE_CHANGE5: tea then one 5 coin.
  - 110 SERVE_CAFE_CHANGE5: coffee then one 5 coin.
  - 111 reserved.
- Handshake:
  - Accept on the rising edge where cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE; cmd is captured into a register at accept.
  - NOP is accepted and dropped: stays IDLE, no done.
- States: IDLE, POUR, COIN_HI, COIN_LO, FIN.
- Transitions:
  - IDLE -> POUR on accepting 001/010/101/110, with down-counter loaded POUR_CYC-1.
  - IDLE -> COIN_HI on accepting 100.
  - IDLE -> FIN with err latched on accepting 011/111.
  - POUR: counter==0 -> COIN_HI if the command carries change, else FIN.
  - COIN_HI holds COIN_PULSE cycles -> COIN_LO.
  - COIN_LO holds COIN_GAP cycles -> FIN.
  - FIN lasts 1 cycle -> IDLE.
- Outputs:
  - Moore, decoded from registered state and captured cmd only; no combinational cmd->actuator path.
  - pump_cafe=POUR & coffee cmd; pump_te=POUR & tea cmd.
  - coin5_out=COIN_HI & (101|110); coin10_out=COIN_HI & 100.
  - done=FIN; err=FIN & reserved; busy=!IDLE.
  - Never both pumps high, never both coin lines high.
- Latency, accept at edge E:
  - Actuator goes high in the cycle after E.
  - Pour commands: pump high exactly POUR_CYC cycles, done at cycle E+POUR_CYC+1 (plus COIN_PULSE+COIN_GAP for change commands).
  - Refund: done at E+COIN_PULSE+COIN_GAP+1.
  - Reserved: done at E+1.
- cmd_ready re-asserts the cycle after FIN; back-to-back commands are allowed with no further dead cycle.
- cmd/cmd_valid changes while busy are ignored. A held cmd_valid is re-accepted once IDLE returns; the controller must drop cmd_valid on seeing done.
- Counter width: $clog2 of the max of POUR_CYC, COIN_PULSE, COIN_GAP, +1; a single counter is shared across states.

Decomposition:
- Package mdc_pkg:
  - command code localparams (CMD_NOP … CMD_RSV7);
  - FSM state encoding;
  - helper function has_change(cmd).
- The controller uses the same package for its out codes.
- Sub-module mdc_temporizador: loadable down-counter with load value, load, en and zero outputs; used for pour, pulse and gap timing.

Test Plan:
- Reset release, idle: cmd_valid=0 -> cmd_ready=1, all other outputs 0 for 20 cycles.
- cmd=010 valid 1 cycle (defaults) -> pump_te high exactly 8 cycles starting cycle after accept; done=1 on cycle 9 after accept, err=0; cmd_ready=1 on cycle 10.
- cmd=101 -> pump_te 8 cycles, then coin5_out high 2 cycles, low 2, done on cycle 13 after accept; coin10_out never high.
- cmd=100 -> coin10_out high cycles 1–2, done on cycle 5 after accept; no pump activity.
- cmd=111 -> done and err high together on cycle 1 after accept, no actuators; cmd=000 -> no done, cmd_ready stays 1.
- cmd=001 then rst=1 asynchronously mid-pour (cycle 4) -> pump_cafe falls before next clk edge; after release, cmd_ready=1, no done; a held cmd_valid with a new command is accepted normally.

Source files
------------

// File: rtl/mdc_pkg.sv
// Shared command codes, FSM encoding and command-decoding helpers for the
// coffee-machine controller and its actuator-side despachador.
package mdc_pkg;

  localparam int unsigned MDC_CMD_W = 3;

  typedef logic [MDC_CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NOP      = 3'b000;
  localparam cmd_t CMD_CAFE     = 3'b001;
  localparam cmd_t CMD_TE       = 3'b010;
  localparam cmd_t CMD_RSV3     = 3'b011;
  localparam cmd_t CMD_RET10    = 3'b100;
  localparam cmd_t CMD_TE_CH5   = 3'b101;
  localparam cmd_t CMD_CAFE_CH5 = 3'b110;
  localparam cmd_t CMD_RSV7     = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StPour,
    StCoinHi,
    StCoinLo,
    StFin
  } state_t;

  // Serve commands that finish with a single 5 coin of change.
  function automatic logic has_change(input cmd_t c);
    return (c == CMD_TE_CH5) || (c == CMD_CAFE_CH5);
  endfunction

  function automatic logic is_cafe(input cmd_t c);
    return (c == CMD_CAFE) || (c == CMD_CAFE_CH5);
  endfunction

  function automatic logic is_te(input cmd_t c);
    return (c == CMD_TE) || (c == CMD_TE_CH5);
  endfunction

  function automatic logic is_pour(input cmd_t c);
    return is_cafe(c) || is_te(c);
  endfunction

  function automatic logic is_reserved(input cmd_t c);
    return (c == CMD_RSV3) || (c == CMD_RSV7);
  endfunction

endpackage

// File: rtl/mdc_temporizador.sv
// Loadable down-counter shared by the pour, coin-pulse and coin-gap phases.
// Load wins over decrement; the count saturates at zero.
module mdc_temporizador #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, decrement while enabled, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mdc_despachador.sv
// Actuator-side responder: accepts one service command, runs the pump for a
// fixed pour time, issues a coin-hopper pulse plus gap when change is due,
// then strobes done (and err for reserved codes). All outputs are Moore,
// decoded from the state register and the captured command.
module mdc_despachador
  import mdc_pkg::*;
#(
  parameter int unsigned CMD_W      = 3,
  parameter int unsigned POUR_CYC   = 8,
  parameter int unsigned COIN_PULSE = 2,
  parameter int unsigned COIN_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             pump_cafe,
  output logic             pump_te,
  output logic             coin5_out,
  output logic             coin10_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned MaxPc  = (POUR_CYC > COIN_PULSE) ? POUR_CYC : COIN_PULSE;
  localparam int unsigned MaxCyc = (MaxPc > COIN_GAP) ? MaxPc : COIN_GAP;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] PourLoad  = CntW'(POUR_CYC - 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(COIN_PULSE - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(COIN_GAP - 1);

  state_t           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [CntW-1:0]  tmr_val;

  mdc_temporizador #(
    .W (CntW)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Next-state logic and timer control.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d = cmd;
          if (is_pour(cmd)) begin
            state_d  = StPour;
            tmr_load = 1'b1;
            tmr_val  = PourLoad;
          end else if (cmd == CMD_RET10) begin
            state_d  = StCoinHi;
            tmr_load = 1'b1;
            tmr_val  = PulseLoad;
          end else if (is_reserved(cmd)) begin
            state_d = StFin;
          end
          // NOP: accepted and dropped.
        end
      end
      StPour: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          if (has_change(cmd_q)) begin
            state_d  = StCoinHi;
            tmr_load = 1'b1;
            tmr_val  = PulseLoad;
          end else begin
            state_d = StFin;
          end
        end
      end
      StCoinHi: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d  = StCoinLo;
          tmr_load = 1'b1;
          tmr_val  = GapLoad;
        end
      end
      StCoinLo: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured-command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Moore outputs; coin5 and coin10 are mutually exclusive by command code.
  always_comb begin
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    pump_cafe  = (state_q == StPour) && is_cafe(cmd_q);
    pump_te    = (state_q == StPour) && is_te(cmd_q);
    coin5_out  = (state_q == StCoinHi) && has_change(cmd_q);
    coin10_out = (state_q == StCoinHi) && (cmd_q == CMD_RET10);
    done       = (state_q == StFin);
    err        = (state_q == StFin) && is_reserved(cmd_q);
  end

endmodule
